// File: rtl/mult_scheduler_pkg.sv
// Shared definitions for the multiplier scheduler: FSM encodings, default
// operand width and the watchdog formula.
package mult_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } schedState;

    localparam int DEFAULT_N = 8;

    // Shift-add core needs about 2N cycles; the extra margin covers handshakes.
    function automatic int timeoutFor(input int n);
        return 2 * n + 4;
    endfunction

endpackage

// File: rtl/mult_scheduler_rr_arb2.sv
// Combinational two-way round-robin pick: a tie goes to the port that was
// not served last, a lone request is granted directly.
module rr_arb2 (
    input  logic Req0,
    input  logic Req1,
    input  logic Last,
    output logic Grant,
    output logic Valid
);

    always_comb begin
        Valid = Req0 | Req1;
        Grant = Req1;
        if (Req0 && Req1) begin
            Grant = ~Last;
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Arbitrates two requesters onto the shared shift-add multiplier core,
// guards each job with a watchdog and returns the product with an ack pulse.
module mult_scheduler
    import mult_scheduler_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int TIMEOUT = timeoutFor(N)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Req0,
    input  logic           Req1,
    input  logic [N-1:0]   A0,
    input  logic [N-1:0]   B0,
    input  logic [N-1:0]   A1,
    input  logic [N-1:0]   B1,
    output logic           Ack0,
    output logic           Ack1,
    output logic [2*N-1:0] Result,
    output logic           Err,
    output logic           Busy,
    output logic           MulStart,
    output logic [N-1:0]   MulA,
    output logic [N-1:0]   MulB,
    input  logic           MulDone,
    input  logic [2*N-1:0] MulP
);

    localparam int CW = $clog2(TIMEOUT + 1);

    schedState      stateReg, stateNext;
    logic           lastReg;
    logic           ownerReg;
    logic           errReg;
    logic [CW-1:0]  cntReg;
    logic [N-1:0]   mulAReg;
    logic [N-1:0]   mulBReg;
    logic [2*N-1:0] resultReg;
    logic           grant;
    logic           grantValid;
    logic [1:0]     ackVec;

    rr_arb2 uArb (
        .Req0  (Req0),
        .Req1  (Req1),
        .Last  (lastReg),
        .Grant (grant),
        .Valid (grantValid)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (grantValid) stateNext = ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    if (MulDone || cntReg == '0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg  <= IDLE;
            lastReg   <= 1'b1;
            ownerReg  <= 1'b0;
            errReg    <= 1'b0;
            cntReg    <= '0;
            mulAReg   <= '0;
            mulBReg   <= '0;
            resultReg <= '0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (grantValid) begin
                        ownerReg <= grant;
                        mulAReg  <= grant ? A1 : A0;
                        mulBReg  <= grant ? B1 : B0;
                        errReg   <= 1'b0;
                    end
                end
                ISSUE: cntReg <= CW'(TIMEOUT);
                WAIT: begin
                    // A done pulse on the last watchdog cycle still counts as success.
                    if (MulDone) begin
                        resultReg <= MulP;
                        errReg    <= 1'b0;
                    end else if (cntReg == '0) begin
                        resultReg <= '0;
                        errReg    <= 1'b1;
                    end else begin
                        cntReg <= cntReg - CW'(1);
                    end
                end
                RESP: lastReg <= ownerReg;
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ackVec[gi] = (stateReg == RESP) && (ownerReg == 1'(gi));
        end
    endgenerate

    assign Ack0     = ackVec[0];
    assign Ack1     = ackVec[1];
    assign Err      = (stateReg == RESP) && errReg;
    assign Busy     = (stateReg != IDLE);
    assign MulStart = (stateReg == ISSUE);
    assign MulA     = mulAReg;
    assign MulB     = mulBReg;
    assign Result   = resultReg;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler with a delay-programmable multiplier core model.
module tb_mult_scheduler;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0;
    logic [7:0]  A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic        Ack0, Ack1, Err, Busy, MulStart;
    logic [15:0] Result;
    logic [7:0]  MulA, MulB;
    logic        MulDone = 1'b0;
    logic [15:0] MulP = '0;

    int tests = 0;
    int failures = 0;

    // Core model: MulDone pulses modelK cycles after MulStart; modelK<=0 means never.
    int          modelK = 0;
    int          modelCnt = 0;
    logic [15:0] modelProd = '0;
    bit          forceDone = 1'b0;

    mult_scheduler #(.N(8), .TIMEOUT(20)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .Req1(Req1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Ack0(Ack0), .Ack1(Ack1), .Result(Result), .Err(Err), .Busy(Busy),
        .MulStart(MulStart), .MulA(MulA), .MulB(MulB),
        .MulDone(MulDone), .MulP(MulP)
    );

    always #5 Clk = ~Clk;

    initial begin
        forever begin
            @(negedge Clk);
            #1;
            MulDone = 1'b0;
            MulP    = '0;
            if (modelCnt > 0) begin
                modelCnt--;
                if (modelCnt == 0) begin
                    MulDone = 1'b1;
                    MulP    = modelProd;
                end
            end
            if (MulStart && modelK > 0) begin
                modelCnt  = modelK;
                modelProd = 16'(MulA) * 16'(MulB);
            end
            if (forceDone) begin
                MulDone = 1'b1;
                MulP    = 16'hBEEF;
            end
        end
    end

    typedef struct {
        bit          port;
        logic [7:0]  a;
        logic [7:0]  b;
        int          k;
        logic [15:0] expResult;
        bit          expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for an ack; optionally checks the issue cycle first.
    task automatic waitAck(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input bit opCheck, output int lat, output int port);
        lat  = -1;
        port = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (opCheck && n == 1) begin
                check({tag, " MulStart"}, 32'(MulStart), 32'd1);
                check({tag, " MulA"}, 32'(MulA), 32'(ea));
                check({tag, " MulB"}, 32'(MulB), 32'(eb));
            end
            if (Ack0 || Ack1) begin
                lat  = n;
                port = (Ack0 && Ack1) ? 2 : (Ack1 ? 1 : 0);
                break;
            end
        end
        if (lat < 0) check({tag, " ack timeout"}, 32'd0, 32'd1);
    endtask

    task automatic applyJob(input vec_t v, input int idx);
        int lat, port;
        string tag;
        tag = $sformatf("vec%0d", idx);
        modelK = v.k;
        if (v.port) begin
            A1 = v.a; B1 = v.b; A0 = 8'hAA; B0 = 8'h55; Req1 = 1'b1;
        end else begin
            A0 = v.a; B0 = v.b; A1 = 8'hAA; B1 = 8'h55; Req0 = 1'b1;
        end
        waitAck(tag, v.a, v.b, 1'b1, lat, port);
        $display("[TB] %s port=%0d lat=%0d result=%0d err=%0d", tag, port, lat, Result, Err);
        check({tag, " port"}, 32'(port), 32'(v.port));
        check({tag, " latency"}, 32'(lat), 32'(v.expLat));
        check({tag, " result"}, 32'(Result), 32'(v.expResult));
        check({tag, " err"}, 32'(Err), 32'(v.expErr));
        Req0 = 1'b0;
        Req1 = 1'b0;
        @(negedge Clk);
        check({tag, " busy after"}, 32'(Busy), 32'd0);
        check({tag, " ack after"}, 32'({Ack1, Ack0}), 32'd0);
    endtask

    initial begin
        int lat, port;
        int altPort[4];
        logic [15:0] altRes[4];

        vecs[0] = '{0, 8'd13,  8'd11,  9, 16'd143,   0, 11};
        vecs[1] = '{1, 8'd2,   8'd3,   1, 16'd6,     0, 3};
        vecs[2] = '{1, 8'd7,   8'd9,   0, 16'd0,     1, 23};
        vecs[3] = '{0, 8'd255, 8'd255, 21, 16'd65025, 0, 23};
        vecs[4] = '{0, 8'd0,   8'd77,  20, 16'd0,     0, 22};
        vecs[5] = '{0, 8'd1,   8'd255, 2, 16'd255,   0, 4};
        vecs[6] = '{1, 8'd200, 8'd100, 5, 16'd20000, 0, 7};

        // Reset state
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset busy", 32'(Busy), 32'd0);
        check("reset acks", 32'({Ack1, Ack0}), 32'd0);
        check("reset err", 32'(Err), 32'd0);
        check("reset mulstart", 32'(MulStart), 32'd0);
        check("reset result", 32'(Result), 32'd0);
        check("reset mulab", 32'({MulA, MulB}), 32'd0);

        for (int i = 0; i < 7; i++) applyJob(vecs[i], i);

        // Both held: grants alternate 0,1,0,1 (Last=1 after vec6)
        A0 = 8'd3; B0 = 8'd5; A1 = 8'd4; B1 = 8'd6; modelK = 2;
        Req0 = 1'b1; Req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            waitAck($sformatf("alt%0d", j), 8'd0, 8'd0, 1'b0, lat, port);
            altPort[j] = port;
            altRes[j]  = Result;
            $display("[TB] alt%0d port=%0d lat=%0d result=%0d", j, port, lat, Result);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("alt%0d port", j), 32'(altPort[j]), 32'(j % 2));
            check($sformatf("alt%0d result", j), 32'(altRes[j]), (j % 2) ? 32'd24 : 32'd15);
        end
        @(negedge Clk);

        // Leave Last=0 and a nonzero Result, then reset during WAIT
        A0 = 8'd3; B0 = 8'd5; modelK = 2; Req0 = 1'b1;
        waitAck("pre", 8'd3, 8'd5, 1'b1, lat, port);
        check("pre result", 32'(Result), 32'd15);
        Req0 = 1'b0;
        @(negedge Clk);
        A0 = 8'd9; B0 = 8'd9; modelK = 0; Req0 = 1'b1;
        repeat (5) @(negedge Clk);
        check("midop busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check("async busy", 32'(Busy), 32'd0);
        check("async result", 32'(Result), 32'd0);
        check("async mulab", 32'({MulA, MulB}), 32'd0);
        check("async pulses", 32'({Ack1, Ack0, Err, MulStart}), 32'd0);
        $display("[TB] reset mid-op busy=%0d result=%0d", Busy, Result);
        Req0 = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        forceDone = 1'b1;
        @(negedge Clk);
        forceDone = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            check($sformatf("stray%0d state", j), 32'({Busy, Ack1, Ack0, Err}), 32'd0);
            check($sformatf("stray%0d result", j), 32'(Result), 32'd0);
        end

        // Tie right after reset: Req0 first, then Req1
        A0 = 8'd255; B0 = 8'd255; A1 = 8'd2; B1 = 8'd3; modelK = 3;
        Req0 = 1'b1; Req1 = 1'b1;
        waitAck("tie0", 8'd255, 8'd255, 1'b1, lat, port);
        $display("[TB] tie0 port=%0d lat=%0d result=%0d", port, lat, Result);
        check("tie0 port", 32'(port), 32'd0);
        check("tie0 latency", 32'(lat), 32'd5);
        check("tie0 result", 32'(Result), 32'd65025);
        Req0 = 1'b0;
        waitAck("tie1", 8'd0, 8'd0, 1'b0, lat, port);
        $display("[TB] tie1 port=%0d lat=%0d result=%0d", port, lat, Result);
        check("tie1 port", 32'(port), 32'd1);
        check("tie1 latency", 32'(lat), 32'd6);
        check("tie1 result", 32'(Result), 32'd6);
        Req1 = 1'b0;
        @(negedge Clk);
        check("final busy", 32'(Busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Sequencer and two-port arbiter for the shared shift-add multiplier core. Two requesters present operand pairs. The block picks one with round-robin priority, loads the core's operands, and pulses its start. It then waits for the core's done pulse, with a watchdog, and returns the product to the owner with a one-cycle acknowledge. It sits between the requesting datapaths and the multiplier's control unit/datapath pair.

## Interface
Parameters:
- N, 8: operand width; product is 2N.
- TIMEOUT, 2*N+4: watchdog limit, counted in WAIT cycles.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Req0, Req1  in  1  request; operands must be held stable while Req is high.
- A0, B0, A1, B1  in  N  operand pairs.
- Ack0, Ack1  out  1  one-cycle pulse; Result and Err are valid in that cycle.
- Result  out  2N  product of the last completed job.
- Err  out  1  high with Ack when the job timed out.
- Busy  out  1  state is not IDLE.
- MulStart  out  1  one-cycle start pulse to the core.
- MulA, MulB  out  N  registered operands to the core.
- MulDone  in  1  one-cycle completion pulse from the core.
- MulP  in  2N  product from the core, valid while MulDone is high.

## Operation
- States and transitions:
  - IDLE→ISSUE on any Req.
  - ISSUE→WAIT unconditionally.
  - WAIT→RESP on MulDone or when Cnt==0.
  - RESP→IDLE unconditionally.
- IDLE, arbitration:
  - Only Req0 high: grant 0. Only Req1 high: grant 1.
  - Both high: grant the port not equal to Last.
  - On the grant edge: Owner<=grant; MulA/MulB<=that port's A/B; ErrR<=0.
- ISSUE: MulStart=1. Cnt<=TIMEOUT.
- WAIT:
  - MulDone=1: Result<=MulP, ErrR<=0.
  - MulDone=0 and Cnt==0: Result<=0, ErrR<=1.
  - Otherwise: Cnt<=Cnt-1.
- RESP: Ack[Owner]=1. Err=ErrR. Last<=Owner.
- Outputs MulStart, Ack0, Ack1, Err and Busy are decoded from registered state only (Moore).
- Requester handshake:
  - The requester drops Req on the edge ending its Ack cycle.
  - Req still high in the following IDLE cycle is treated as a new request.
- Result holds its value until the next WAIT exit.
- Width rules: Cnt is clog2(TIMEOUT+1) bits. No arithmetic is performed on data.

## Timing
- Reset values: state IDLE, Last=1 (Req0 wins the first tie), Owner=0, MulA=MulB=0, Result=0, ErrR=0, Cnt=0. All pulse outputs 0, Busy=0.
- Latency: Req seen in IDLE at cycle t → MulStart at t+1 → first WAIT cycle t+2.
  - MulDone at cycle d ≥ t+2 → Ack at d+1.
  - Minimum request-to-Ack latency is 3 cycles.
- Timeout: with no MulDone, RESP occurs at t+TIMEOUT+3 with Err=1.
- Boundary conditions:
  - MulDone in the same cycle as Cnt==0: done wins, Err=0.
  - MulDone outside WAIT: ignored.
  - Req changes outside IDLE: ignored.
  - Reset mid-operation: immediate return to reset values; no Ack is issued; the in-flight job is lost. The core shares Reset.
- Back-to-back jobs: the next grant can occur in the IDLE cycle directly after RESP.

## Structure
- Shared package/include holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - default N
  - TIMEOUT formula
- One sub-module is natural: rr_arb2, the combinational two-way round-robin pick from (Req0, Req1, Last). It is reusable by other shared-resource blocks.
- Everything else is a single clocked process plus output decode.

## Test plan
(N=8, TIMEOUT=20; the core model pulses MulDone k cycles after MulStart.)
- Req0 with A0=13, B0=11, k=9, Req at t → MulStart at t+1 with MulA=13, MulB=11; Ack0 at t+11 with Result=143, Err=0; Ack1 never asserted.
- Req0 and Req1 rising together after reset, A0=B0=255, A1=2, B1=3 → Ack0 first with Result=65025, then Ack1 with Result=6.
- Req1 held continuously while Req0 re-requests immediately after each Ack → grants alternate 0,1,0,1 over 4 jobs.
- Model never pulses MulDone, Req1 at t → Ack1 and Err=1 at t+23 with Result=0; Busy falls at t+24.
- MulDone coinciding with Cnt==0 (k=21) → Ack with Err=0 and Result=MulP.
- Reset asserted during WAIT, then a stray MulDone in IDLE → all outputs return to reset values immediately; no Ack; no state change from the stray MulDone.
